ls_chan_est: RTL and testbench
==============================

LS_CHAN_EST -- requirements
Module: ls_chan_est

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning width of one real/imag component.
REQ-002 SHALL have parameter FRAC_WIDTH, default 12, meaning fractional bits (Q4.12).
REQ-003 SHALL have parameter INV_SQRT2, default 2896, meaning 1/sqrt(2) in Q4.12.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, exactly as listed in REQ-005/006.
REQ-005 i_clk_est  input  1  sole clock, rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_start_est  input  1  start pulse, honoured only in IDLE.
REQ-008 i_smooth_en  input  1  enable 3-tap frequency smoothing pass, sampled with start.
REQ-009 i_pilot_rx  input  [11:0] x 2*DATA_WIDTH  received DMRS symbol per subcarrier, {re,im} signed.
REQ-010 i_dmrs  input  [11:0] x 2  reference QPSK per subcarrier: bit1=1 means re negative, bit0=1 means im negative.
REQ-011 o_h  output  [11:0] x 2*DATA_WIDTH  channel estimate {re,im} signed Q4.12, registered; feeds equalizer i_h.
REQ-012 o_est_done12  output  12  bit k high when o_h[k] is final; feeds equalizer i_est_done12.
REQ-013 o_est_done  output  1  one-cycle pulse, whole estimate final.
REQ-014 o_busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE, CALC, SMOOTH, DONE; one subcarrier per cycle in CALC and SMOOTH, index k counts 0..11.
REQ-016 IDLE with i_start_est=1 at an edge: register i_pilot_rx, i_dmrs, i_smooth_en; clear o_est_done12; k=0; go CALC.
REQ-017 CALC arithmetic, with a=+/-1 from i_dmrs[k][1] and b=+/-1 from i_dmrs[k][0]: s_re=a*yr+b*yi, s_im=a*yi-b*yr, each in 17 bits.
REQ-018 o_h[k] re/im = (s*INV_SQRT2) arithmetic shift right FRAC_WIDTH, truncated, then saturated to [-32768, 32767].
REQ-019 CALC writes o_h[k] at each edge; if smoothing is disabled, the same edge sets o_est_done12[k]; after k=11 go SMOOTH if smoothing is enabled, else DONE.
REQ-020 SMOOTH: h'[k]=(h[k-1]+2*h[k]+h[k+1]) arithmetic shift right 2 per component, computed in DATA_WIDTH+2 bits; no saturation is needed.
REQ-021 Edges replicate: h[-1]=h[0], h[12]=h[11].
REQ-022 SMOOTH updates o_h in place, holding the unsmoothed h[k-1] in a private register; o_est_done12[k] is set on the same edge that writes h'[k].
REQ-023 After k=11 in SMOOTH go DONE; DONE asserts o_est_done for one cycle, then returns to IDLE; o_h and o_est_done12 hold until the next start.
REQ-024 Latency, start edge E0 to o_est_done high: 13 edges without smoothing, 25 edges with smoothing.
REQ-025 i_start_est while o_busy=1 SHALL be ignored, with no restart and no state change.
REQ-026 Input changes after the start edge SHALL NOT affect the result.
REQ-027 An i_start_est in DONE is ignored; a new start is accepted in IDLE on the next cycle.

Reset
REQ-028 i_rst_n low at any time SHALL immediately force: state IDLE, k=0, o_h all zero, o_est_done12=0, o_est_done=0, o_busy=0, captured registers zero.
REQ-029 Reset mid-CALC or mid-SMOOTH abandons the estimate; no done pulse follows the release of reset.

Verification
REQ-030 Basic: all yr=4096, yi=0, dmrs=00, smooth off -> every o_h=(2896,-2896); done12 bit k rises at E(k+1); o_est_done at E13.
REQ-031 Sign: yr=0, yi=4096, dmrs=11 (a=b=-1) -> o_h=(-2896,-2896) for all k.
REQ-032 Saturation: yr=yi=32767, dmrs=00 -> o_h re=32767, im=0; with dmrs=11 -> re=-32768, im=0.
REQ-033 Smoothing: only subcarrier 5 has yr=4096 (others 0), dmrs=00, smooth on -> h[4]=h[6]=(724,-724), h[5]=(1448,-1448), others 0; o_est_done at E25; with smooth off, h[5]=(2896,-2896).
REQ-034 Busy/reset: start pulse at E5 during CALC is ignored (done still at E13); in a second run, i_rst_n low at E7 -> all outputs zero asynchronously and no o_est_done afterwards.

Source files
------------

// File: rtl/ls_chan_est_if.sv
// Handshake and data bundle between a DMRS pilot source and the LS channel estimator.
// Per-subcarrier words are packed {re, im}, re in the upper half.
interface ls_chan_est_if #(
  parameter int DATA_WIDTH = 16
);
  logic                           i_start_est;
  logic                           i_smooth_en;
  logic [11:0][2*DATA_WIDTH-1:0]  i_pilot_rx;
  logic [11:0][1:0]               i_dmrs;
  logic [11:0][2*DATA_WIDTH-1:0]  o_h;
  logic [11:0]                    o_est_done12;
  logic                           o_est_done;
  logic                           o_busy;

  modport master (
    output i_start_est, i_smooth_en, i_pilot_rx, i_dmrs,
    input  o_h, o_est_done12, o_est_done, o_busy
  );

  modport slave (
    input  i_start_est, i_smooth_en, i_pilot_rx, i_dmrs,
    output o_h, o_est_done12, o_est_done, o_busy
  );
endinterface

// File: rtl/ls_chan_est.sv
// Least-squares channel estimate over 12 DMRS subcarriers, one subcarrier per cycle,
// with an optional in-place 3-tap [1 2 1]/4 frequency smoothing pass.
module ls_chan_est #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 12,
  parameter int INV_SQRT2  = 2896
) (
  input logic          i_clk_est,
  input logic          i_rst_n,
  ls_chan_est_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int MW = 2 * DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 1;
  localparam int AW = DATA_WIDTH + 2;
  localparam int PW = SW + 32;

  localparam logic signed [PW-1:0] InvSqrt2 = PW'(INV_SQRT2);
  localparam logic signed [PW-1:0] MaxV     = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] MinV     = -MaxV - PW'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StSmooth, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            k_q;
  logic [11:0][MW-1:0]   pilot_q;
  logic [11:0][1:0]      dmrs_q;
  logic                  smooth_q;
  logic [11:0][MW-1:0]   h_q;
  logic [11:0]           done12_q;
  logic                  done_q;
  logic [MW-1:0]         prev_q;
  logic                  last_k;

  assign last_k = (k_q == 4'd11);

  function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] x);
    if (x > MaxV) return DW'(MaxV);
    if (x < MinV) return DW'(MinV);
    return DW'(x);
  endfunction

  function automatic logic [DW-1:0] avg3(input logic signed [DW-1:0] l,
                                         input logic signed [DW-1:0] c,
                                         input logic signed [DW-1:0] r);
    logic signed [AW-1:0] sum;
    sum = AW'(l) + (AW'(c) <<< 1) + AW'(r);
    return DW'(sum >>> 2);
  endfunction

  // LS estimate: y * conj(x) with x = (a + jb)/sqrt2, a,b = +/-1
  logic signed [DW-1:0] yr, yi;
  logic signed [SW-1:0] yr_x, yi_x, s_re, s_im;
  logic signed [PW-1:0] p_re, p_im;
  logic [MW-1:0]        calc_h;

  always_comb begin
    yr     = pilot_q[k_q][MW-1:DW];
    yi     = pilot_q[k_q][DW-1:0];
    yr_x   = SW'(yr);
    yi_x   = SW'(yi);
    s_re   = (dmrs_q[k_q][1] ? -yr_x : yr_x) + (dmrs_q[k_q][0] ? -yi_x : yi_x);
    s_im   = (dmrs_q[k_q][1] ? -yi_x : yi_x) - (dmrs_q[k_q][0] ? -yr_x : yr_x);
    p_re   = PW'(s_re) * InvSqrt2;
    p_im   = PW'(s_im) * InvSqrt2;
    calc_h = {sat(p_re >>> FRAC_WIDTH), sat(p_im >>> FRAC_WIDTH)};
  end

  // prev_q keeps the unsmoothed left neighbour since h_q[k-1] is already overwritten
  logic [MW-1:0] left, cent, right, smooth_h;

  always_comb begin
    left     = (k_q == 4'd0) ? h_q[0] : prev_q;
    cent     = h_q[k_q];
    right    = last_k ? h_q[11] : h_q[k_q + 4'd1];
    smooth_h = {avg3(left[MW-1:DW], cent[MW-1:DW], right[MW-1:DW]),
                avg3(left[DW-1:0], cent[DW-1:0], right[DW-1:0])};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.i_start_est) state_d = StCalc;
      StCalc:   if (last_k) state_d = smooth_q ? StSmooth : StDone;
      StSmooth: if (last_k) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_est or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk_est or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q      <= '0;
      pilot_q  <= '0;
      dmrs_q   <= '0;
      smooth_q <= 1'b0;
      h_q      <= '0;
      done12_q <= '0;
      done_q   <= 1'b0;
      prev_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_start_est) begin
            pilot_q  <= bus.i_pilot_rx;
            dmrs_q   <= bus.i_dmrs;
            smooth_q <= bus.i_smooth_en;
            done12_q <= '0;
            k_q      <= '0;
          end
        end
        StCalc: begin
          h_q[k_q] <= calc_h;
          if (!smooth_q) done12_q[k_q] <= 1'b1;
          k_q <= last_k ? 4'd0 : k_q + 4'd1;
        end
        StSmooth: begin
          h_q[k_q]      <= smooth_h;
          prev_q        <= cent;
          done12_q[k_q] <= 1'b1;
          k_q <= last_k ? 4'd0 : k_q + 4'd1;
        end
        StDone:  done_q <= 1'b1;
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign bus.o_h          = h_q;
  assign bus.o_est_done12 = done12_q;
  assign bus.o_est_done   = done_q;
  assign bus.o_busy       = (state_q != StIdle);
endmodule

// File: tb/tb_ls_chan_est.sv
// Scoreboard bench for ls_chan_est: each start pushes the expected estimate and done edge;
// a monitor pops and compares whenever o_est_done is seen.
module tb_ls_chan_est;
  localparam int DW = 16;

  typedef logic [11:0][2*DW-1:0] harr_t;
  typedef logic [11:0][1:0]      dmrs_t;
  typedef struct {
    harr_t h;
    int    done_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  ls_chan_est_if #(.DATA_WIDTH(DW)) bus ();

  ls_chan_est #(
    .DATA_WIDTH(DW),
    .FRAC_WIDTH(12),
    .INV_SQRT2 (2896)
  ) dut (
    .i_clk_est(clk),
    .i_rst_n  (rst_n),
    .bus      (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  function automatic harr_t uni(input int re, input int im);
    harr_t h;
    for (int k = 0; k < 12; k++) h[k] = pk(re, im);
    return h;
  endfunction

  function automatic dmrs_t dm_all(input logic [1:0] v);
    dmrs_t d;
    for (int k = 0; k < 12; k++) d[k] = v;
    return d;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.o_est_done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at edge %0d expected none", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_edge", edge_cnt, e.done_edge);
        check("done12_final", 32'(bus.o_est_done12), 32'hfff);
        for (int k = 0; k < 12; k++) check($sformatf("h[%0d]", k), bus.o_h[k], e.h[k]);
      end
    end
  end

  // Start on the next edge (E0); inputs are scrambled right after to prove they were captured
  task automatic start_run(input harr_t p, input dmrs_t d, input logic sm, input harr_t eh,
                           input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    bus.i_pilot_rx  = p;
    bus.i_dmrs      = d;
    bus.i_smooth_en = sm;
    bus.i_start_est = 1'b1;
    e.h         = eh;
    e.done_edge = edge_cnt + 1 + lat;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.i_start_est = 1'b0;
    bus.i_pilot_rx  = uni(-12345, 777);
    bus.i_dmrs      = dm_all(2'b01);
    bus.i_smooth_en = ~sm;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    check("busy_after_done", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done12"}, 32'(bus.o_est_done12), 32'd0);
    check({tag, "_done"}, 32'(bus.o_est_done), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    for (int k = 0; k < 12; k++) check($sformatf("%s_h[%0d]", tag, k), bus.o_h[k], 32'd0);
  endtask

  initial begin
    harr_t p, eh;
    dmrs_t d;
    bus.i_start_est = 1'b0;
    bus.i_smooth_en = 1'b0;
    bus.i_pilot_rx  = '0;
    bus.i_dmrs      = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic run with done12 progression and an ignored start at E5
    start_run(uni(4096, 0), dm_all(2'b00), 1'b0, uni(2896, -2896), 13, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("done12_E%0d", i), 32'(bus.o_est_done12), (32'd1 << i) - 32'd1);
      if (i == 4) begin
        check("busy_calc", 32'(bus.o_busy), 32'd1);
        bus.i_start_est = 1'b1;
      end
      if (i == 5) bus.i_start_est = 1'b0;
    end
    wait_done();

    // Sign
    start_run(uni(0, 4096), dm_all(2'b11), 1'b0, uni(-2896, -2896), 13, 1'b1);
    wait_done();

    // Saturation
    start_run(uni(32767, 32767), dm_all(2'b00), 1'b0, uni(32767, 0), 13, 1'b1);
    wait_done();
    start_run(uni(32767, 32767), dm_all(2'b11), 1'b0, uni(-32768, 0), 13, 1'b1);
    wait_done();

    // Per-subcarrier QPSK pattern, y = 4096 + j2048
    for (int k = 0; k < 12; k++) begin
      d[k] = 2'(k % 4);
      case (k % 4)
        0:       eh[k] = pk(4344, -1448);
        1:       eh[k] = pk(1448, 4344);
        2:       eh[k] = pk(-1448, -4344);
        default: eh[k] = pk(-4344, 1448);
      endcase
    end
    start_run(uni(4096, 2048), d, 1'b0, eh, 13, 1'b1);
    wait_done();

    // Single-tone smoothing, then the same tone unsmoothed
    p = uni(0, 0);
    p[5] = pk(4096, 0);
    eh = uni(0, 0);
    eh[4] = pk(724, -724);
    eh[5] = pk(1448, -1448);
    eh[6] = pk(724, -724);
    start_run(p, dm_all(2'b00), 1'b1, eh, 25, 1'b1);
    wait_done();
    eh = uni(0, 0);
    eh[5] = pk(2896, -2896);
    start_run(p, dm_all(2'b00), 1'b0, eh, 13, 1'b1);
    wait_done();

    // Flat channel through smoothing stays flat only if edges replicate
    start_run(uni(4096, 0), dm_all(2'b00), 1'b1, uni(2896, -2896), 25, 1'b1);
    wait_done();

    // Reset mid-CALC: outputs clear at once and no done pulse follows
    start_run(uni(4096, 0), dm_all(2'b00), 1'b0, uni(0, 0), 13, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    // Estimator still usable after the abandoned run
    start_run(uni(0, 4096), dm_all(2'b11), 1'b0, uni(-2896, -2896), 13, 1'b1);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
